matrix_column_scanner: RTL

//  Display-side consumer of the five 7-bit column patterns produced by game selection (col1..col5).

---
 rtl/matrix_column_scanner.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/matrix_column_scanner.sv
// Time-multiplexed 7x5 LED matrix driver with frame-boundary snapshot of the column patterns.
// Optional blink feature is compiled in with `define MATRIX_BLINK_EN.
module matrix_column_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter bit ROW_ACTIVE_LOW = 1'b1,
   parameter bit COL_ACTIVE_LOW = 1'b1,
   parameter int BLINK_FRAMES   = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [6:0] col1_in,
   input  logic [6:0] col2_in,
   input  logic [6:0] col3_in,
   input  logic [6:0] col4_in,
   input  logic [6:0] col5_in,
   input  logic       blink,
   output logic [6:0] row_out,
   output logic [4:0] col_sel,
   output logic [2:0] col_idx,
   output logic       frame_start
);

   localparam int             CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
   localparam logic [6:0]     ROW_OFF = ROW_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [4:0]     COL_OFF = COL_ACTIVE_LOW ? 5'h1F : 5'h00;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       col_idx_q, col_idx_d;
   logic [6:0]       snap_q [5];
   logic [6:0]       snap_d [5];
   logic             frame_start_q, frame_start_d;
   logic [6:0]       row_q, row_d;
   logic [4:0]       col_sel_q, col_sel_d;
   logic             tick, wrap;
   logic             visible;
   logic [6:0]       cur_pattern;
   logic [4:0]       col_onehot;

`ifdef MATRIX_BLINK_EN
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] FC_MAX = FC_W'(BLINK_FRAMES - 1);

   logic [FC_W-1:0] fc_q, fc_d;
   logic            phase_q, phase_d;

   always_comb begin
      fc_d    = fc_q;
      phase_d = phase_q;
      if (wrap) begin
         if (fc_q == FC_MAX) begin
            fc_d    = '0;
            phase_d = ~phase_q;
         end else begin
            fc_d = fc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fc_q    <= '0;
         phase_q <= 1'b0;
      end else begin
         fc_q    <= fc_d;
         phase_q <= phase_d;
      end
   end

   assign visible = ~(blink & phase_q);
`else
   logic unused_blink;
   assign unused_blink = blink & (BLINK_FRAMES > 0);
   assign visible      = 1'b1;
`endif

   always_comb begin
      cur_pattern = 7'h00;
      case (col_idx_q)
         3'd0:    cur_pattern = snap_q[0];
         3'd1:    cur_pattern = snap_q[1];
         3'd2:    cur_pattern = snap_q[2];
         3'd3:    cur_pattern = snap_q[3];
         3'd4:    cur_pattern = snap_q[4];
         default: cur_pattern = 7'h00;
      endcase
   end

   assign col_onehot = 5'b00001 << col_idx_q;

   always_comb begin
      tick          = enable && (cnt_q == CNT_MAX);
      wrap          = tick && (col_idx_q == 3'd4);
      cnt_d         = cnt_q;
      col_idx_d     = col_idx_q;
      for (int k = 0; k < 5; k++) snap_d[k] = snap_q[k];
      frame_start_d = wrap;
      row_d         = ROW_OFF;
      col_sel_d     = COL_OFF;

      if (enable) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
      if (tick) begin
         col_idx_d = wrap ? 3'd0 : col_idx_q + 3'd1;
      end
      // New patterns are only accepted at the frame boundary so a frame never tears.
      if (wrap) begin
         snap_d[0] = col1_in;
         snap_d[1] = col2_in;
         snap_d[2] = col3_in;
         snap_d[3] = col4_in;
         snap_d[4] = col5_in;
      end

      // Rows stay dark for the first cycle of each slot to hide ghosting of the previous column.
      if (enable) begin
         col_sel_d = COL_ACTIVE_LOW ? ~col_onehot : col_onehot;
         if ((cnt_q != '0) && visible) begin
            row_d = ROW_ACTIVE_LOW ? ~cur_pattern : cur_pattern;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         col_idx_q     <= 3'd0;
         for (int k = 0; k < 5; k++) snap_q[k] <= 7'h00;
         frame_start_q <= 1'b0;
         row_q         <= ROW_OFF;
         col_sel_q     <= COL_OFF;
      end else begin
         cnt_q         <= cnt_d;
         col_idx_q     <= col_idx_d;
         for (int k = 0; k < 5; k++) snap_q[k] <= snap_d[k];
         frame_start_q <= frame_start_d;
         row_q         <= row_d;
         col_sel_q     <= col_sel_d;
      end
   end

   assign row_out     = row_q;
   assign col_sel     = col_sel_q;
   assign col_idx     = col_idx_q;
   assign frame_start = frame_start_q;

endmodule
